// File: rtl/lapido_instr_encoder.sv
// Packs field-level encode requests into 32-bit Lapido instruction words and writes the
// legal ones to instruction memory at consecutive addresses via a we/ack handshake.
module lapido_instr_encoder #(
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_class,
  input  logic [4:0]            in_func,
  input  logic [3:0]            in_rc,
  input  logic [3:0]            in_ra,
  input  logic [3:0]            in_rb,
  input  logic [15:0]           in_imm,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ack,
  output logic                  illegal,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   word_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LAST = '1;
  localparam logic [ADDR_WIDTH:0]   ONE  = (ADDR_WIDTH+1)'(1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  illegal_q, illegal_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;

  logic        enc_legal;
  logic [4:0]  enc_f;
  logic [31:0] enc_word;
  logic        accept;

  // Encoder: decides legality and builds the word; nop forces an all-zero word.
  always_comb begin
    enc_legal = 1'b0;
    enc_f     = 5'd0;
    enc_word  = 32'd0;
    case (in_class)
      3'b000: enc_legal = 1'b1;
      3'b001: begin
        enc_legal = in_func[4] |
                    (in_func inside {5'b00000, 5'b00001, 5'b00011, 5'b00100,
                                     5'b00101, 5'b00110, 5'b01000, 5'b01001});
        enc_f     = in_func;
      end
      3'b100: begin
        enc_legal = (in_func[4:1] == 4'd0);
        enc_f     = {4'b0000, in_func[0]};
      end
      3'b010: begin
        enc_legal = (in_func[4:2] == 3'd0) && (in_func[1:0] != 2'b11);
        enc_f     = {3'b000, in_func[1:0]};
      end
      3'b101: begin
        enc_legal = (in_func < 5'd5);
        enc_f     = {in_func[2:0], 2'b00};
      end
      default: enc_legal = 1'b0;
    endcase
    if (in_class != 3'b000) begin
      enc_word = {in_class, enc_f, in_rc, in_ra,
                  (in_class == 3'b001) ? {in_rb, 12'h000} : in_imm};
    end
  end

  assign in_ready = (state_q == IDLE) & ~start;
  assign accept   = in_valid & in_ready;

  // start overrides everything, including an ack arriving in the same cycle.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    count_d   = count_q;
    illegal_d = 1'b0;
    if (start) begin
      state_d = IDLE;
      addr_d  = BASE;
      count_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (enc_legal) begin
              wdata_d = enc_word;
              state_d = WRITE;
            end else begin
              illegal_d = 1'b1;
            end
          end
        end
        WRITE: begin
          if (mem_ack) begin
            count_d = count_q + ONE;
            if (addr_q == LAST) begin
              state_d = FULL;
            end else begin
              addr_d  = addr_q + 1'b1;
              state_d = IDLE;
            end
          end
        end
        FULL:    state_d = FULL;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      addr_q    <= BASE;
      wdata_q   <= 32'd0;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
    end
  end

  assign mem_we     = (state_q == WRITE);
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign illegal    = illegal_q;
  assign full       = (state_q == FULL);
  assign word_count = count_q;

endmodule

// File: tb/tb_lapido_instr_encoder.sv
// Directed self-checking bench for lapido_instr_encoder: a default-width instance for encoding
// and handshake scenarios, plus an ADDR_WIDTH=2 instance for the full condition.
module tb_lapido_instr_encoder;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic        in_valid;
  logic        in_valid2;
  logic [2:0]  in_class;
  logic [4:0]  in_func;
  logic [3:0]  in_rc;
  logic [3:0]  in_ra;
  logic [3:0]  in_rb;
  logic [15:0] in_imm;
  logic        mem_ack;
  logic        mem_ack2;

  logic        in_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        illegal;
  logic        full;
  logic [8:0]  word_count;

  logic        in_ready2;
  logic        mem_we2;
  logic [1:0]  mem_addr2;
  logic [31:0] mem_wdata2;
  logic        illegal2;
  logic        full2;
  logic [2:0]  word_count2;

  int checks = 0;
  int errors = 0;

  lapido_instr_encoder dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_class(in_class), .in_func(in_func), .in_rc(in_rc), .in_ra(in_ra),
    .in_rb(in_rb), .in_imm(in_imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .illegal(illegal), .full(full), .word_count(word_count)
  );

  lapido_instr_encoder #(.ADDR_WIDTH(2), .BASE_ADDR(0)) dut2 (
    .clock(clock), .reset_n(reset_n), .start(start),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .in_class(in_class), .in_func(in_func), .in_rc(in_rc), .in_ra(in_ra),
    .in_rb(in_rb), .in_imm(in_imm),
    .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_ack(mem_ack2),
    .illegal(illegal2), .full(full2), .word_count(word_count2)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Inputs are driven and outputs sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic to_second, input logic [2:0] cls, input logic [4:0] fn,
                      input logic [3:0] rc, input logic [3:0] ra, input logic [3:0] rb,
                      input logic [15:0] imm);
    in_class = cls;
    in_func  = fn;
    in_rc    = rc;
    in_ra    = ra;
    in_rb    = rb;
    in_imm   = imm;
    if (to_second) in_valid2 = 1'b1;
    else           in_valid  = 1'b1;
    step();
    in_valid  = 1'b0;
    in_valid2 = 1'b0;
  endtask

  task automatic ack_once();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_valid2 = 1'b0;
    mem_ack = 1'b0; mem_ack2 = 1'b0;
    in_class = 3'd0; in_func = 5'd0; in_rc = 4'd0; in_ra = 4'd0; in_rb = 4'd0; in_imm = 16'd0;
    step();
    step();
    checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_we: got %b expected 0", mem_we); end
    checks++; if (mem_addr !== 8'd0) begin errors++; $display("[TB] FAIL reset_addr: got %h expected 00", mem_addr); end
    checks++; if (mem_wdata !== 32'd0) begin errors++; $display("[TB] FAIL reset_wdata: got %h expected 0", mem_wdata); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("[TB] FAIL reset_illegal: got %b expected 0", illegal); end
    checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full: got %b expected 0", full); end
    checks++; if (word_count !== 9'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", word_count); end
    reset_n = 1'b1;
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_alu_add();
    send(1'b0, 3'b001, 5'b00000, 4'd1, 4'd2, 4'd3, 16'hFFFF);
    checks++; if (mem_we !== 1'b1) begin errors++; $display("[TB] FAIL add_we: got %b expected 1", mem_we); end
    checks++; if (mem_wdata !== 32'h2012_3000) begin errors++; $display("[TB] FAIL add_wdata: got %h expected 20123000", mem_wdata); end
    checks++; if (mem_addr !== 8'd0) begin errors++; $display("[TB] FAIL add_addr: got %h expected 00", mem_addr); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL add_ready_busy: got %b expected 0", in_ready); end
    step();
    checks++; if (mem_we !== 1'b1 || mem_wdata !== 32'h2012_3000) begin errors++; $display("[TB] FAIL add_hold: we %b data %h expected 1 20123000", mem_we, mem_wdata); end
    ack_once();
    checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL add_we_drop: got %b expected 0", mem_we); end
    checks++; if (word_count !== 9'd1) begin errors++; $display("[TB] FAIL add_count: got %0d expected 1", word_count); end
    checks++; if (mem_addr !== 8'd1) begin errors++; $display("[TB] FAIL add_next_addr: got %h expected 01", mem_addr); end
  endtask

  task automatic test_memory();
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (mem_addr !== 8'd0 || word_count !== 9'd0) begin errors++; $display("[TB] FAIL mem_restart: addr %h count %0d expected 00 0", mem_addr, word_count); end
    send(1'b0, 3'b100, 5'd0, 4'd4, 4'd5, 4'd9, 16'h0010);
    checks++; if (mem_wdata !== 32'h8045_0010 || mem_addr !== 8'd0) begin errors++; $display("[TB] FAIL mem_load: data %h addr %h expected 80450010 00", mem_wdata, mem_addr); end
    ack_once();
    send(1'b0, 3'b100, 5'd1, 4'd4, 4'd5, 4'd9, 16'h0010);
    checks++; if (mem_wdata !== 32'h8145_0010 || mem_addr !== 8'd1) begin errors++; $display("[TB] FAIL mem_store: data %h addr %h expected 81450010 01", mem_wdata, mem_addr); end
    ack_once();
    checks++; if (word_count !== 9'd2) begin errors++; $display("[TB] FAIL mem_count: got %0d expected 2", word_count); end
  endtask

  // Each word is acked on its first write cycle: one word per two cycles.
  task automatic test_back_to_back();
    send(1'b0, 3'b101, 5'd1, 4'd1, 4'd2, 4'd0, 16'h0008);
    checks++; if (mem_wdata !== 32'hA412_0008 || mem_addr !== 8'd2) begin errors++; $display("[TB] FAIL beq: data %h addr %h expected A4120008 02", mem_wdata, mem_addr); end
    ack_once();
    send(1'b0, 3'b101, 5'd4, 4'd0, 4'd7, 4'd0, 16'h0000);
    checks++; if (mem_wdata !== 32'hB007_0000 || mem_addr !== 8'd3) begin errors++; $display("[TB] FAIL jr: data %h addr %h expected B0070000 03", mem_wdata, mem_addr); end
    ack_once();
    send(1'b0, 3'b010, 5'd2, 4'd3, 4'd0, 4'd0, 16'hBEEF);
    checks++; if (mem_wdata !== 32'h4230_BEEF || mem_addr !== 8'd4) begin errors++; $display("[TB] FAIL lcl: data %h addr %h expected 4230BEEF 04", mem_wdata, mem_addr); end
    ack_once();
    send(1'b0, 3'b000, 5'd31, 4'd15, 4'd15, 4'd15, 16'hFFFF);
    checks++; if (mem_we !== 1'b1 || mem_wdata !== 32'h0000_0000) begin errors++; $display("[TB] FAIL nop: we %b data %h expected 1 00000000", mem_we, mem_wdata); end
    ack_once();
    checks++; if (word_count !== 9'd6 || mem_addr !== 8'd6) begin errors++; $display("[TB] FAIL b2b_count: count %0d addr %h expected 6 06", word_count, mem_addr); end
  endtask

  task automatic test_illegal();
    logic [2:0] cls [3];
    logic [4:0] fn  [3];
    cls[0] = 3'b001; fn[0] = 5'b00010;
    cls[1] = 3'b111; fn[1] = 5'b00000;
    cls[2] = 3'b101; fn[2] = 5'd5;
    for (int i = 0; i < 3; i++) begin
      send(1'b0, cls[i], fn[i], 4'd1, 4'd2, 4'd3, 16'h1234);
      checks++; if (illegal !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("[TB] FAIL illegal_pulse%0d: illegal %b we %b expected 1 0", i, illegal, mem_we); end
      step();
      checks++; if (illegal !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("[TB] FAIL illegal_end%0d: illegal %b we %b expected 0 0", i, illegal, mem_we); end
      checks++; if (mem_addr !== 8'd6 || word_count !== 9'd6 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL illegal_state%0d: addr %h count %0d ready %b expected 06 6 1", i, mem_addr, word_count, in_ready); end
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 3'b001, 5'b00001, 4'(i), 4'd2, 4'd3, 16'h0000);
      checks++; if (mem_we2 !== 1'b1 || mem_addr2 !== 2'(i)) begin errors++; $display("[TB] FAIL full_write%0d: we %b addr %0d expected 1 %0d", i, mem_we2, mem_addr2, i); end
      step(); step(); step();
      checks++; if (mem_we2 !== 1'b1) begin errors++; $display("[TB] FAIL full_hold%0d: got %b expected 1", i, mem_we2); end
      mem_ack2 = 1'b1;
      step();
      mem_ack2 = 1'b0;
      checks++; if (mem_we2 !== 1'b0 || word_count2 !== 3'(i + 1)) begin errors++; $display("[TB] FAIL full_ack%0d: we %b count %0d expected 0 %0d", i, mem_we2, word_count2, i + 1); end
      checks++; if (full2 !== (i == 3)) begin errors++; $display("[TB] FAIL full_flag%0d: got %b expected %b", i, full2, (i == 3)); end
    end
    checks++; if (in_ready2 !== 1'b0 || mem_addr2 !== 2'd3 || word_count2 !== 3'd4) begin errors++; $display("[TB] FAIL full_state: ready %b addr %0d count %0d expected 0 3 4", in_ready2, mem_addr2, word_count2); end
    send(1'b1, 3'b001, 5'b00000, 4'd1, 4'd1, 4'd1, 16'h0000);
    checks++; if (mem_we2 !== 1'b0 || full2 !== 1'b1 || mem_addr2 !== 2'd3) begin errors++; $display("[TB] FAIL full_reject: we %b full %b addr %0d expected 0 1 3", mem_we2, full2, mem_addr2); end
  endtask

  task automatic test_start_abort();
    send(1'b0, 3'b001, 5'b00000, 4'd1, 4'd2, 4'd3, 16'h0000);
    checks++; if (mem_we !== 1'b1) begin errors++; $display("[TB] FAIL abort_we: got %b expected 1", mem_we); end
    start   = 1'b1;
    mem_ack = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL abort_ready_start: got %b expected 0", in_ready); end
    step();
    start   = 1'b0;
    mem_ack = 1'b0;
    #1;
    checks++; if (mem_we !== 1'b0 || mem_addr !== 8'd0 || word_count !== 9'd0) begin errors++; $display("[TB] FAIL abort_state: we %b addr %h count %0d expected 0 00 0", mem_we, mem_addr, word_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL abort_ready: got %b expected 1", in_ready); end
    checks++; if (full2 !== 1'b0 || word_count2 !== 3'd0 || in_ready2 !== 1'b1) begin errors++; $display("[TB] FAIL abort_full_clear: full %b count %0d ready %b expected 0 0 1", full2, word_count2, in_ready2); end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    checks++; if (word_count !== 9'd0 || mem_we !== 1'b0) begin errors++; $display("[TB] FAIL stray_ack: count %0d we %b expected 0 0", word_count, mem_we); end
  endtask

  initial begin
    $display("[TB] starting lapido_instr_encoder bench");
    test_reset();
    test_alu_add();
    test_memory();
    test_back_to_back();
    test_illegal();
    test_full();
    test_start_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
